jtag_tap_sampled: RTL

//  JTAG TAP controller that consumes the sim JTAG driver outputs (TCK/TMS/TDI/TRSTn) and returns TDO data/driven.
//  TCK is oversampled on the system clock; no second clock domain exists.

---
 rtl/jtag_pkg.sv | 56 +++++
 rtl/jtag_tap_fsm.sv | 43 ++++
 rtl/jtag_tap_sampled.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/jtag_pkg.sv
// jtag_pkg: shared types and helpers for the oversampled JTAG TAP.
//   tap_state_e  - the 16 IEEE 1149.1 TAP states, 4-bit encoding
//   next_state() - standard TAP transition function for one TCK rise
//   *_DEF        - default instruction opcodes and IDCODE value
package jtag_pkg;

  typedef enum logic [3:0] {
    TEST_LOGIC_RESET = 4'h0,
    RUN_TEST_IDLE    = 4'h1,
    SELECT_DR_SCAN   = 4'h2,
    CAPTURE_DR       = 4'h3,
    SHIFT_DR         = 4'h4,
    EXIT1_DR         = 4'h5,
    PAUSE_DR         = 4'h6,
    EXIT2_DR         = 4'h7,
    UPDATE_DR        = 4'h8,
    SELECT_IR_SCAN   = 4'h9,
    CAPTURE_IR       = 4'hA,
    SHIFT_IR         = 4'hB,
    EXIT1_IR         = 4'hC,
    PAUSE_IR         = 4'hD,
    EXIT2_IR         = 4'hE,
    UPDATE_IR        = 4'hF
  } tap_state_e;

  localparam logic [4:0]  IR_IDCODE_DEF  = 5'h01;
  localparam logic [4:0]  IR_USER_DEF    = 5'h11;
  localparam logic [4:0]  IR_BYPASS_DEF  = 5'h1F;
  localparam logic [31:0] IDCODE_VAL_DEF = 32'h0000_0001;

  function automatic tap_state_e next_state(input tap_state_e cur, input logic tms);
    tap_state_e nxt;
    nxt = TEST_LOGIC_RESET;
    case (cur)
      TEST_LOGIC_RESET: nxt = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
      RUN_TEST_IDLE:    nxt = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      SELECT_DR_SCAN:   nxt = tms ? SELECT_IR_SCAN   : CAPTURE_DR;
      CAPTURE_DR:       nxt = tms ? EXIT1_DR         : SHIFT_DR;
      SHIFT_DR:         nxt = tms ? EXIT1_DR         : SHIFT_DR;
      EXIT1_DR:         nxt = tms ? UPDATE_DR        : PAUSE_DR;
      PAUSE_DR:         nxt = tms ? EXIT2_DR         : PAUSE_DR;
      EXIT2_DR:         nxt = tms ? UPDATE_DR        : SHIFT_DR;
      UPDATE_DR:        nxt = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      SELECT_IR_SCAN:   nxt = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
      CAPTURE_IR:       nxt = tms ? EXIT1_IR         : SHIFT_IR;
      SHIFT_IR:         nxt = tms ? EXIT1_IR         : SHIFT_IR;
      EXIT1_IR:         nxt = tms ? UPDATE_IR        : PAUSE_IR;
      PAUSE_IR:         nxt = tms ? EXIT2_IR         : PAUSE_IR;
      EXIT2_IR:         nxt = tms ? UPDATE_IR        : SHIFT_IR;
      UPDATE_IR:        nxt = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      default:          nxt = TEST_LOGIC_RESET;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// jtag_tap_fsm: TAP state register. Advances one 1149.1 transition per
// qualified TCK rise; force_tlr parks the controller in Test-Logic-Reset and
// wins over any advance in the same cycle.
// Ports:
//   clock, reset  system clock, synchronous active-high reset
//   advance       one-cycle strobe: a TCK rising edge was detected
//   tms           sampled TMS, used only when advance is high
//   force_tlr     asynchronous-to-TCK TAP reset request (sampled TRSTn low)
//   state         current TAP state
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       advance,
  input  logic       tms,
  input  logic       force_tlr,
  output tap_state_e state
);

  tap_state_e state_q;
  tap_state_e state_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= TEST_LOGIC_RESET;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (force_tlr) begin
      state_d = TEST_LOGIC_RESET;
    end else if (advance) begin
      state_d = next_state(state_q, tms);
    end
  end

  assign state = state_q;

endmodule

// File: rtl/jtag_tap_sampled.sv
// jtag_tap_sampled: IEEE 1149.1 TAP controller running entirely in the system
// clock domain. TCK/TMS/TDI/TRSTn are sampled as data and TCK edges are
// recovered by comparing two successive samples.
// Registers: IR, BYPASS, IDCODE (32 bit) and a USER data register whose
// Update-DR value is handed to the debug fabric over a valid/ready port.
// Build option: define JTAG_INPUT_SYNC_EN to put a 2-flop synchronizer in
// front of the sample stage (adds 2 cycles of input latency; TCK high/low
// must then last at least 3 clocks instead of 2).
// Ports:
//   clock, reset                       system clock, synchronous active-high reset
//   jtag_TCK/TMS/TDI/TRSTn             JTAG pins from the driver
//   jtag_TDO_data, jtag_TDO_driven     serial out, and "TDO carries shift data"
//   dr_cap_data                        USER value captured at Capture-DR
//   dr_upd_valid/ready, dr_upd_data    USER update handshake
//   dr_overrun                         one-cycle pulse: an update was dropped
//   tap_state                          current TAP state encoding
module jtag_tap_sampled
  import jtag_pkg::*;
#(
  parameter int                  IR_WIDTH   = 5,
  parameter int                  DR_WIDTH   = 41,
  parameter logic [31:0]         IDCODE_VAL = IDCODE_VAL_DEF,
  parameter logic [IR_WIDTH-1:0] IR_IDCODE  = IR_WIDTH'(IR_IDCODE_DEF),
  parameter logic [IR_WIDTH-1:0] IR_USER    = IR_WIDTH'(IR_USER_DEF)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                jtag_TCK,
  input  logic                jtag_TMS,
  input  logic                jtag_TDI,
  input  logic                jtag_TRSTn,
  output logic                jtag_TDO_data,
  output logic                jtag_TDO_driven,
  input  logic [DR_WIDTH-1:0] dr_cap_data,
  output logic                dr_upd_valid,
  input  logic                dr_upd_ready,
  output logic [DR_WIDTH-1:0] dr_upd_data,
  output logic                dr_overrun,
  output logic [3:0]          tap_state
);

  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(2'b01);

  logic tck_in, tms_in, tdi_in, trstn_in;

`ifdef JTAG_INPUT_SYNC_EN
  // ---- synchronizer stage: two flops per pin ----
  logic [1:0] tck_sync, tms_sync, tdi_sync, trstn_sync;

  always_ff @(posedge clock) begin
    if (reset) begin
      tck_sync   <= 2'b00;
      tms_sync   <= 2'b00;
      tdi_sync   <= 2'b00;
      trstn_sync <= 2'b11;
    end else begin
      tck_sync   <= {tck_sync[0],   jtag_TCK};
      tms_sync   <= {tms_sync[0],   jtag_TMS};
      tdi_sync   <= {tdi_sync[0],   jtag_TDI};
      trstn_sync <= {trstn_sync[0], jtag_TRSTn};
    end
  end

  assign tck_in   = tck_sync[1];
  assign tms_in   = tms_sync[1];
  assign tdi_in   = tdi_sync[1];
  assign trstn_in = trstn_sync[1];
`else
  assign tck_in   = jtag_TCK;
  assign tms_in   = jtag_TMS;
  assign tdi_in   = jtag_TDI;
  assign trstn_in = jtag_TRSTn;
`endif

  // ---- sample stage ----
  logic s_tck, s_tck_d, s_tms, s_tdi, s_trstn;

  // TRSTn idles high through reset so leaving reset is not itself a TAP reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      s_tck   <= 1'b0;
      s_tck_d <= 1'b0;
      s_tms   <= 1'b0;
      s_tdi   <= 1'b0;
      s_trstn <= 1'b1;
    end else begin
      s_tck   <= tck_in;
      s_tck_d <= s_tck;
      s_tms   <= tms_in;
      s_tdi   <= tdi_in;
      s_trstn <= trstn_in;
    end
  end

  logic tck_rise, tck_fall, trst_force;

  assign tck_rise   = s_tck & ~s_tck_d;
  assign tck_fall   = ~s_tck & s_tck_d;
  assign trst_force = ~s_trstn;

  // ---- TAP state machine ----
  tap_state_e state;

  jtag_tap_fsm u_fsm (
    .clock     (clock),
    .reset     (reset),
    .advance   (tck_rise),
    .tms       (s_tms),
    .force_tlr (trst_force),
    .state     (state)
  );

  assign tap_state = state;

  // TRSTn overrides any TCK edge seen in the same cycle.
  logic rise_en, fall_en;

  assign rise_en = tck_rise & ~trst_force;
  assign fall_en = tck_fall & ~trst_force;

  // ---- instruction decode ----
  logic [IR_WIDTH-1:0] ir;
  logic                sel_idcode, sel_user;

  // Anything that is neither IDCODE nor USER (including all-ones) is BYPASS.
  assign sel_idcode = (ir == IR_IDCODE);
  assign sel_user   = (ir == IR_USER);

  // ---- shift registers ----
  logic [IR_WIDTH-1:0] ir_shift;
  logic [31:0]         idcode_shift;
  logic [DR_WIDTH-1:0] user_shift;
  logic                bypass_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      ir_shift     <= '0;
      idcode_shift <= '0;
      user_shift   <= '0;
      bypass_reg   <= 1'b0;
    end else if (rise_en) begin
      case (state)
        CAPTURE_IR: ir_shift <= IR_CAPTURE;
        SHIFT_IR:   ir_shift <= {s_tdi, ir_shift[IR_WIDTH-1:1]};
        CAPTURE_DR: begin
          if (sel_idcode) begin
            idcode_shift <= IDCODE_VAL;
          end else if (sel_user) begin
            user_shift <= dr_cap_data;
          end else begin
            bypass_reg <= 1'b0;
          end
        end
        SHIFT_DR: begin
          if (sel_idcode) begin
            idcode_shift <= {s_tdi, idcode_shift[31:1]};
          end else if (sel_user) begin
            user_shift <= {s_tdi, user_shift[DR_WIDTH-1:1]};
          end else begin
            bypass_reg <= s_tdi;
          end
        end
        default: ;
      endcase
    end
  end

  // ---- instruction register ----
  // Update happens on the falling TCK edge inside Update-IR, the usual 1149.1
  // point; the new opcode only matters from the next Capture-DR onward.
  always_ff @(posedge clock) begin
    if (reset) begin
      ir <= IR_IDCODE;
    end else if (trst_force || (state == TEST_LOGIC_RESET)) begin
      ir <= IR_IDCODE;
    end else if (fall_en && (state == UPDATE_IR)) begin
      ir <= ir_shift;
    end
  end

  // ---- TDO output ----
  logic dr_lsb;
  logic in_shift;

  always_comb begin
    dr_lsb = bypass_reg;
    if (sel_idcode) begin
      dr_lsb = idcode_shift[0];
    end else if (sel_user) begin
      dr_lsb = user_shift[0];
    end
  end

  assign in_shift = (state == SHIFT_IR) || (state == SHIFT_DR);

  always_ff @(posedge clock) begin
    if (reset) begin
      jtag_TDO_data   <= 1'b0;
      jtag_TDO_driven <= 1'b0;
    end else if (fall_en) begin
      jtag_TDO_data   <= (state == SHIFT_IR) ? ir_shift[0] : dr_lsb;
      jtag_TDO_driven <= in_shift;
    end
  end

  // ---- USER update handshake ----
  // A new update is taken if the slot is empty or is being drained this very
  // cycle; otherwise it is dropped and flagged. TRSTn leaves a pending update
  // alone so the fabric never loses an already-delivered value.
  logic upd_fire, upd_accept;

  assign upd_fire   = fall_en && (state == UPDATE_DR) && sel_user;
  assign upd_accept = dr_upd_valid & dr_upd_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      dr_upd_valid <= 1'b0;
      dr_upd_data  <= '0;
      dr_overrun   <= 1'b0;
    end else begin
      dr_overrun <= 1'b0;
      if (upd_fire) begin
        if (!dr_upd_valid || upd_accept) begin
          dr_upd_valid <= 1'b1;
          dr_upd_data  <= user_shift;
        end else begin
          dr_overrun <= 1'b1;
        end
      end else if (upd_accept) begin
        dr_upd_valid <= 1'b0;
      end
    end
  end

endmodule
